// File: rtl/coin_accumulator.sv
// coin_accumulator: front-end money stage of the vending machine.
// Collects 1/5/10-unit coins into a registered credit, dispenses on a
// successful purchase and pays out change or a cancelled credit one coin at
// a time over a ready/valid handshake to the coin hopper.
// Optional feature macro: AUTO_REFUND_EN (idle-timeout automatic refund).
module coin_accumulator #(
  parameter int AMT_W       = 5,
  parameter int MAX_AMOUNT  = 31,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  input  logic             cancel,
  input  logic             buy,
  input  logic [AMT_W-1:0] product_price,
  input  logic             change_ready,
  output logic [AMT_W-1:0] current_amount,
  output logic             coin_reject,
  output logic             dispense,
  output logic             change_valid,
  output logic [1:0]       change_coin,
  output logic             busy
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    RETURN  = 1'b1
  } state_t;

  localparam logic [AMT_W:0]   MaxSum = (AMT_W+1)'(MAX_AMOUNT);
  localparam logic [AMT_W-1:0] Ten    = AMT_W'(10);
  localparam logic [AMT_W-1:0] Five   = AMT_W'(5);

  // Reject parameter sets whose credit ceiling cannot be held on the bus.
  if (MAX_AMOUNT > (2**AMT_W) - 1 || MAX_AMOUNT < 0 || TIMEOUT_CYC < 1) begin : gBadParams
    $error("coin_accumulator: MAX_AMOUNT must fit in AMT_W bits and TIMEOUT_CYC must be >= 1");
  end

  // Denomination code to unit value; the invalid code maps to zero.
  function automatic logic [AMT_W-1:0] coinValue(input logic [1:0] code);
    logic [AMT_W-1:0] v;
    case (code)
      2'b00:   v = AMT_W'(1);
      2'b01:   v = AMT_W'(5);
      2'b10:   v = AMT_W'(10);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Largest coin that does not exceed the remaining credit.
  function automatic logic [1:0] pickCoin(input logic [AMT_W-1:0] amt);
    logic [1:0] c;
    if (amt >= Ten) begin
      c = 2'b10;
    end else if (amt >= Five) begin
      c = 2'b01;
    end else begin
      c = 2'b00;
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [AMT_W-1:0] amount_q, amount_d;
  logic             coinReject_q, coinReject_d;
  logic             dispense_q, dispense_d;
  logic             changeValid_q, changeValid_d;
  logic [1:0]       changeCoin_q, changeCoin_d;
  logic             busy_q, busy_d;

  logic [AMT_W:0]   coinSum;
  logic [AMT_W-1:0] remainder;
  logic [AMT_W-1:0] afterChange;
  logic             cancelTake;
  logic             buyTake;
  logic             coinOk;

`ifdef AUTO_REFUND_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IdleMax = IDLE_W'(TIMEOUT_CYC);

  logic [IDLE_W-1:0] idleCnt_q, idleCnt_d;
  logic [IDLE_W-1:0] idleNext;
`endif

  // Decode accepted commands and the arithmetic shared by the next-state logic.
  always_comb begin
    cancelTake  = cancel && (amount_q != '0);
    buyTake     = !cancelTake && buy && (amount_q >= product_price);
    coinSum     = {1'b0, amount_q} + {1'b0, coinValue(coin_type)};
    coinOk      = (coin_type != 2'b11) && (coinSum <= MaxSum);
    remainder   = amount_q - product_price;
    afterChange = amount_q - coinValue(changeCoin_q);
  end

  // Next-state and registered-output logic for the COLLECT/RETURN machine.
  always_comb begin
    state_d       = state_q;
    amount_d      = amount_q;
    coinReject_d  = 1'b0;
    dispense_d    = 1'b0;
    changeValid_d = changeValid_q;
    changeCoin_d  = changeCoin_q;
    busy_d        = busy_q;
`ifdef AUTO_REFUND_EN
    idleCnt_d     = '0;
    idleNext      = idleCnt_q + IDLE_W'(1);
`endif

    case (state_q)
      COLLECT: begin
        if (cancelTake) begin
          coinReject_d  = coin_valid;
          state_d       = RETURN;
          changeValid_d = 1'b1;
          busy_d        = 1'b1;
          changeCoin_d  = pickCoin(amount_q);
        end else if (buyTake) begin
          coinReject_d = coin_valid;
          dispense_d   = 1'b1;
          if (product_price != '0) begin
            amount_d = remainder;
            if (remainder != '0) begin
              state_d       = RETURN;
              changeValid_d = 1'b1;
              busy_d        = 1'b1;
              changeCoin_d  = pickCoin(remainder);
            end
          end
        end else if (coin_valid) begin
          if (coinOk) begin
            amount_d = coinSum[AMT_W-1:0];
          end else begin
            coinReject_d = 1'b1;
          end
        end else begin
`ifdef AUTO_REFUND_EN
          if (!buy && !cancel && (amount_q != '0)) begin
            if (idleNext == IdleMax) begin
              state_d       = RETURN;
              changeValid_d = 1'b1;
              busy_d        = 1'b1;
              changeCoin_d  = pickCoin(amount_q);
            end else begin
              idleCnt_d = idleNext;
            end
          end
`endif
        end
      end

      RETURN: begin
        coinReject_d = coin_valid;
        if (changeValid_q && change_ready) begin
          amount_d = afterChange;
          if (afterChange == '0) begin
            state_d       = COLLECT;
            changeValid_d = 1'b0;
            busy_d        = 1'b0;
            changeCoin_d  = 2'b00;
          end else begin
            changeCoin_d  = pickCoin(afterChange);
          end
        end
      end

      default: begin
        state_d       = COLLECT;
        amount_d      = '0;
        changeValid_d = 1'b0;
        busy_d        = 1'b0;
        changeCoin_d  = 2'b00;
      end
    endcase
  end

  // State and output registers; reset discards any credit still being paid out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      amount_q      <= '0;
      coinReject_q  <= 1'b0;
      dispense_q    <= 1'b0;
      changeValid_q <= 1'b0;
      changeCoin_q  <= 2'b00;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      amount_q      <= amount_d;
      coinReject_q  <= coinReject_d;
      dispense_q    <= dispense_d;
      changeValid_q <= changeValid_d;
      changeCoin_q  <= changeCoin_d;
      busy_q        <= busy_d;
    end
  end

`ifdef AUTO_REFUND_EN
  // Idle timer; the next-state logic keeps it at zero outside idle COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idleCnt_q <= '0;
    end else begin
      idleCnt_q <= idleCnt_d;
    end
  end
`endif

  assign current_amount = amount_q;
  assign coin_reject    = coinReject_q;
  assign dispense       = dispense_q;
  assign change_valid   = changeValid_q;
  assign change_coin    = changeCoin_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed scoreboard bench for coin_accumulator.
module tb_coin_accumulator;

  typedef struct {
    string      tag;
    logic [4:0] amt;
    logic       rej;
    logic       disp;
    logic       cv;
    logic [1:0] coin;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coinValid = 1'b0;
  logic [1:0] coinType = 2'b00;
  logic       cancelIn = 1'b0;
  logic       buyIn = 1'b0;
  logic [4:0] price = 5'd0;
  logic       changeReady = 1'b0;
  logic [4:0] currentAmount;
  logic       coinReject;
  logic       dispenseOut;
  logic       changeValid;
  logic [1:0] changeCoin;
  logic       busyOut;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount = 0;
  int   failCount = 0;

  coin_accumulator #(
    .AMT_W(5),
    .MAX_AMOUNT(31),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .coin_valid(coinValid),
    .coin_type(coinType),
    .cancel(cancelIn),
    .buy(buyIn),
    .product_price(price),
    .change_ready(changeReady),
    .current_amount(currentAmount),
    .coin_reject(coinReject),
    .dispense(dispenseOut),
    .change_valid(changeValid),
    .change_coin(changeCoin),
    .busy(busyOut)
  );

  // Free-running 10-unit clock period.
  always #5 clk = ~clk;

  task automatic checkField(input string tag, input string name, input logic [4:0] obs, input logic [4:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL scoreboard empty observed=0 expected=1");
      return;
    end
    e = expQ.pop_front();
    checkField(e.tag, "amount", currentAmount, e.amt);
    checkField(e.tag, "reject", {4'd0, coinReject}, {4'd0, e.rej});
    checkField(e.tag, "dispense", {4'd0, dispenseOut}, {4'd0, e.disp});
    checkField(e.tag, "changeValid", {4'd0, changeValid}, {4'd0, e.cv});
    checkField(e.tag, "changeCoin", {3'd0, changeCoin}, {3'd0, e.coin});
    checkField(e.tag, "busy", {4'd0, busyOut}, {4'd0, e.busy});
  endtask

  task automatic expectNow(input string tag, input logic [4:0] eAmt, input logic eRej, input logic eDisp,
                           input logic eCv, input logic [1:0] eCoin, input logic eBusy);
    exp_t e;
    e.tag = tag; e.amt = eAmt; e.rej = eRej; e.disp = eDisp;
    e.cv = eCv; e.coin = eCoin; e.busy = eBusy;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input string tag, input logic cv, input logic [1:0] ct, input logic can,
                               input logic by, input logic [4:0] pr, input logic rdy,
                               input logic [4:0] eAmt, input logic eRej, input logic eDisp,
                               input logic eCv, input logic [1:0] eCoin, input logic eBusy);
    @(negedge clk);
    coinValid = cv; coinType = ct; cancelIn = can; buyIn = by; price = pr; changeReady = rdy;
    expectNow(tag, eAmt, eRej, eDisp, eCv, eCoin, eBusy);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset values, observed while reset is still held.
    #1;
    expectNow("reset", 5'd0, 0, 0, 0, 2'b00, 0);
    checkOutput();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Coins 10,10,5,1 accumulate.
    applyStimulus("coin10a", 1, 2'b10, 0, 0, 5'd0, 0, 5'd10, 0, 0, 0, 2'b00, 0);
    applyStimulus("coin10b", 1, 2'b10, 0, 0, 5'd0, 0, 5'd20, 0, 0, 0, 2'b00, 0);
    applyStimulus("coin5",   1, 2'b01, 0, 0, 5'd0, 0, 5'd25, 0, 0, 0, 2'b00, 0);
    applyStimulus("coin1",   1, 2'b00, 0, 0, 5'd0, 0, 5'd26, 0, 0, 0, 2'b00, 0);

    // Overflow rejection, exact ceiling acceptance, then one past the ceiling.
    applyStimulus("over36",  1, 2'b10, 0, 0, 5'd0, 0, 5'd26, 1, 0, 0, 2'b00, 0);
    applyStimulus("rejDrop", 0, 2'b00, 0, 0, 5'd0, 0, 5'd26, 0, 0, 0, 2'b00, 0);
    applyStimulus("max31",   1, 2'b01, 0, 0, 5'd0, 0, 5'd31, 0, 0, 0, 2'b00, 0);
    applyStimulus("over32",  1, 2'b00, 0, 0, 5'd0, 0, 5'd31, 1, 0, 0, 2'b00, 0);

    // Purchase with change 8 -> 5,1,1,1.
    applyStimulus("buy23",   0, 2'b00, 0, 1, 5'd23, 0, 5'd8, 0, 1, 1, 2'b01, 1);
    applyStimulus("chg5",    0, 2'b00, 0, 0, 5'd0, 1, 5'd3, 0, 0, 1, 2'b00, 1);
    applyStimulus("chg1a",   0, 2'b00, 0, 0, 5'd0, 1, 5'd2, 0, 0, 1, 2'b00, 1);
    applyStimulus("chg1b",   0, 2'b00, 0, 0, 5'd0, 1, 5'd1, 0, 0, 1, 2'b00, 1);
    applyStimulus("chg1c",   0, 2'b00, 0, 0, 5'd0, 1, 5'd0, 0, 0, 0, 2'b00, 0);

    // Invalid coin type at zero credit; free product at zero credit.
    applyStimulus("badType", 1, 2'b11, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 2'b00, 0);
    applyStimulus("price0",  0, 2'b00, 0, 1, 5'd0, 0, 5'd0, 0, 1, 0, 2'b00, 0);
    applyStimulus("cancel0", 0, 2'b00, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'b00, 0);

    // Insufficient credit, then cancel with a simultaneous coin.
    applyStimulus("c15a",    1, 2'b10, 0, 0, 5'd0, 0, 5'd10, 0, 0, 0, 2'b00, 0);
    applyStimulus("c15b",    1, 2'b01, 0, 0, 5'd0, 0, 5'd15, 0, 0, 0, 2'b00, 0);
    applyStimulus("buyLow",  0, 2'b00, 0, 1, 5'd20, 0, 5'd15, 0, 0, 0, 2'b00, 0);
    applyStimulus("cancCoin",1, 2'b00, 1, 0, 5'd0, 0, 5'd15, 1, 0, 1, 2'b10, 1);
    applyStimulus("hold1",   0, 2'b00, 0, 0, 5'd0, 0, 5'd15, 0, 0, 1, 2'b10, 1);
    applyStimulus("hold2",   1, 2'b01, 0, 1, 5'd0, 0, 5'd15, 1, 0, 1, 2'b10, 1);
    applyStimulus("hold3",   0, 2'b00, 1, 0, 5'd0, 0, 5'd15, 0, 0, 1, 2'b10, 1);
    applyStimulus("ref10",   0, 2'b00, 0, 0, 5'd0, 1, 5'd5, 0, 0, 1, 2'b01, 1);
    applyStimulus("ref5",    0, 2'b00, 0, 0, 5'd0, 1, 5'd0, 0, 0, 0, 2'b00, 0);

    // Asynchronous reset in the middle of a refund of 7.
    applyStimulus("r7a",     1, 2'b01, 0, 0, 5'd0, 0, 5'd5, 0, 0, 0, 2'b00, 0);
    applyStimulus("r7b",     1, 2'b00, 0, 0, 5'd0, 0, 5'd6, 0, 0, 0, 2'b00, 0);
    applyStimulus("r7c",     1, 2'b00, 0, 0, 5'd0, 0, 5'd7, 0, 0, 0, 2'b00, 0);
    applyStimulus("r7canc",  0, 2'b00, 1, 0, 5'd0, 0, 5'd7, 0, 0, 1, 2'b01, 1);
    coinValid = 0; cancelIn = 0;
    #2;
    rst_n = 1'b0;
    #1;
    expectNow("asyncRst", 5'd0, 0, 0, 0, 2'b00, 0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("postRst", 1, 2'b00, 0, 0, 5'd0, 0, 5'd1, 0, 0, 0, 2'b00, 0);
    applyStimulus("canc1",   0, 2'b00, 1, 0, 5'd0, 0, 5'd1, 0, 0, 1, 2'b00, 1);
    applyStimulus("ref1",    0, 2'b00, 0, 0, 5'd0, 1, 5'd0, 0, 0, 0, 2'b00, 0);

    // Idle behaviour with credit 5.
    applyStimulus("idle5",   1, 2'b01, 0, 0, 5'd0, 0, 5'd5, 0, 0, 0, 2'b00, 0);
`ifdef AUTO_REFUND_EN
    begin
      int waited = 0;
      @(negedge clk);
      coinValid = 0; changeReady = 0;
      while (changeValid !== 1'b1 && waited < 40) begin
        @(posedge clk);
        #1;
        waited++;
      end
      expectNow("autoRef", 5'd5, 0, 0, 1, 2'b01, 1);
      checkOutput();
      checkField("autoRef", "cycles", 5'(waited), 5'd20);
      applyStimulus("autoRet", 0, 2'b00, 0, 0, 5'd0, 1, 5'd0, 0, 0, 0, 2'b00, 0);
    end
`else
    for (int i = 0; i < 100; i++) begin
      applyStimulus("hold5", 0, 2'b00, 0, 0, 5'd0, 0, 5'd5, 0, 0, 0, 2'b00, 0);
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
